sobel_window_scanner: RTL and testbench
=======================================

Name: sobel_window_scanner

Overview:
- Next-generation window extractor feeding the Sobel datapath. It captures a 3-row pixel line buffer and emits 3x3 windows under a valid/ready handshake.
- Two run modes: a single window at a chosen column, or an auto-scan that issues one window per column from start_col to the row end.
- Edge handling at the right border is selectable: wrap, zero-pad or replicate.

Parameters:
- PIX_W, 8, bits per pixel.
- ROW_LEN, 8, pixels per buffered row; must be >= 3.
- COL_W, $clog2(ROW_LEN), width of column indices (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  capture in_buffer and begin; honoured only in IDLE.
- in_buffer  in  [2:0][ROW_LEN-1:0][PIX_W-1:0]  3 rows; element [ROW_LEN-1] is the leftmost pixel.
- start_col  in  COL_W  first window column (0 = leftmost).
- scan_all  in  1  0 = single window; 1 = scan start_col..ROW_LEN-1.
- edge_mode  in  2  0 wrap, 1 zero-pad, 2 replicate, 3 reserved (behaves as zero-pad).
- out_ready  in  1  consumer accepts the current window.
- win_valid  out  1  sobel_matrix/win_col/last are valid.
- sobel_matrix  out  [2:0][2:0][PIX_W-1:0]  window; [r][2] is leftmost, [r][0] is rightmost.
- win_col  out  COL_W  column of the presented window.
- last  out  1  presented window is the final one of the run.
- busy  out  1  high in SCAN.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (async, rst=1): state IDLE. win_valid, last, busy and err are 0; sobel_matrix and win_col are 0; the shadow buffer is cleared.
- States:
  - IDLE -> SCAN on start=1 with start_col < ROW_LEN.
  - SCAN -> IDLE on an accept (win_valid & out_ready) while last=1.
- Start rejection: start with start_col >= ROW_LEN is ignored, stays in IDLE, and pulses err for one cycle. start while in SCAN is ignored with no err.
- Capture at start:
  - in_buffer goes into the shadow register.
  - edge_mode and scan_all are latched.
  - The column counter loads start_col.
  - Later changes to any of these inputs have no effect until the next start.
- Latency: the first window is registered. win_valid=1 on the cycle after the start edge, so the output is ready 1 clock after start.
- Window mapping: for column c, window offset j = 0..2, and row r:
  - Source index s = c + j.
  - If s < ROW_LEN: sobel_matrix[r][2-j] = shadow[r][ROW_LEN-1-s].
  - If s >= ROW_LEN:
    - wrap: shadow[r][ROW_LEN-1-(s-ROW_LEN)].
    - zero-pad: 0.
    - replicate: shadow[r][0].
- Handshake:
  - While win_valid=1 and out_ready=0, all outputs hold stable.
  - On an accept with last=0: the counter increments and the next window registers on the same edge, so win_valid stays 1. Throughput is 1 window per clock.
  - On an accept with last=1: win_valid, last and busy drop to 0 on the next cycle, and sobel_matrix holds its final value.
- last = (scan_all_latched == 0) or (win_col == ROW_LEN-1).
  - A single-window run has exactly 1 window.
  - An auto-scan run has ROW_LEN - start_col windows.
- Simultaneous events: start together with the final accept is ignored, because the FSM is still in SCAN on that edge.
- Reset mid-run: immediate return to reset values. There is no partial output and no err.
- Width: all index arithmetic is COL_W+1 bits, so c+2 does not overflow.

Decomposition:
- sobel_pkg holds:
  - edge_mode_t enum {EDGE_WRAP, EDGE_ZERO, EDGE_REPL, EDGE_RSVD}.
  - scan_state_t {IDLE, SCAN}.
  - localparam KERNEL = 3.
- Sub-module sobel_col_select: a combinational mux that takes one shadow row, the column and the edge mode, and returns 3 pixels. It is instantiated 3 times, once per row.
- The top level holds the FSM, counter, shadow register and output registers.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs are 0 immediately.
- Single, wrap:
  - Stimulus: rows = {5,55,50,100,0,0,0,0}, start_col=6, scan_all=0, edge_mode=0, out_ready=1.
  - Response: 1 cycle later, win_valid=1, last=1, each row = {0,0,5}, win_col=6. The next cycle, win_valid=0 and busy=0.
- Single, zero-pad and replicate:
  - Stimulus: same rows, start_col=7, edge_mode=1.
  - Response: rows = {0,0,0}.
  - Repeat with edge_mode=2 and rows = {0,55,50,100,0,20,0,9}, start_col=7 -> rows = {9,9,9}.
- Auto-scan with backpressure:
  - Stimulus: rows = {100,100,100,0,0,0,0,0}, start_col=4, scan_all=1, edge_mode=1; hold out_ready=0 for 3 cycles, then 1.
  - Response: windows are presented for win_col 4,5,6,7, and the win_col=4 window stays stable while stalled.
  - Each window's rows are {0,0,0}, and last=1 only at win_col=7.
  - Repeat with start_col=0 and out_ready=1 -> 8 back-to-back windows with no bubble; the win_col=0 window rows = {100,100,100}, and the win_col=1 window rows = {100,100,0}.
- Rejects:
  - start during SCAN -> ignored, no err.
  - With ROW_LEN=6, start_col=7 -> err pulses once, state stays IDLE, win_valid=0.
- Reset mid-run: assert rst during an auto-scan at win_col=5 -> win_valid=0 and busy=0 immediately. A fresh start then works normally.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scanner.
//   edge_mode_t  : right-border policy (wrap, zero-pad, replicate, reserved = zero-pad)
//   scan_state_t : scanner FSM states
//   KERNEL       : window height/width (3x3)
package sobel_pkg;

  localparam int KERNEL = 3;

  typedef enum logic [1:0] {
    EDGE_WRAP = 2'd0,
    EDGE_ZERO = 2'd1,
    EDGE_REPL = 2'd2,
    EDGE_RSVD = 2'd3
  } edge_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sobel_col_select.sv
// Combinational 3-tap column selector for one buffered row.
//   row       : ROW_LEN pixels, element [ROW_LEN-1] is the leftmost pixel
//   col       : leftmost column of the window (0 = leftmost)
//   edge_mode : policy for taps that fall past the right border
//   pix       : 3 pixels, pix[2] leftmost tap, pix[0] rightmost tap
module sobel_col_select
  import sobel_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ROW_LEN = 8,
  parameter int COL_W   = $clog2(ROW_LEN)
) (
  input  logic [ROW_LEN-1:0][PIX_W-1:0] row,
  input  logic [COL_W-1:0]              col,
  input  logic [1:0]                    edge_mode,
  output logic [KERNEL-1:0][PIX_W-1:0]  pix
);

  // One spare bit so col+2 never overflows.
  localparam logic [COL_W:0] ROW_LEN_W  = (COL_W+1)'(ROW_LEN);
  localparam logic [COL_W:0] LAST_IDX_W = (COL_W+1)'(ROW_LEN - 1);

  for (genvar j = 0; j < KERNEL; j++) begin : g_tap
    logic [COL_W:0]   src_col;
    logic [COL_W:0]   wrap_col;
    logic [COL_W-1:0] elem;
    logic [PIX_W-1:0] tap;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
      src_col  = {1'b0, col} + (COL_W+1)'(j);
      wrap_col = (src_col < ROW_LEN_W) ? src_col : src_col - ROW_LEN_W;
      // Columns count from the left, buffer elements from the right.
      elem     = COL_W'(LAST_IDX_W - wrap_col);
      tap      = '0;
      if (src_col < ROW_LEN_W) begin
        tap = row[elem];
      end else begin
        case (edge_mode_t'(edge_mode))
          EDGE_WRAP: tap = row[elem];
          EDGE_REPL: tap = row[0];
          default:   tap = '0;  // zero-pad and reserved
        endcase
      end
    end

    assign pix[KERNEL-1-j] = tap;
  end

endmodule

// File: rtl/sobel_window_scanner.sv
// 3x3 window extractor for the Sobel datapath.
// Captures three rows on start and presents one window per accepted handshake,
// either a single window at start_col or every column from start_col to the row end.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : capture in_buffer/start_col/scan_all/edge_mode (IDLE only)
//   in_buffer     : 3 rows of ROW_LEN pixels, element [ROW_LEN-1] leftmost
//   start_col     : first window column
//   scan_all      : 0 single window, 1 scan to the last column
//   edge_mode     : right-border policy (see sobel_pkg::edge_mode_t)
//   out_ready     : consumer accepts the presented window
//   win_valid     : sobel_matrix/win_col/last valid
//   sobel_matrix  : window, [r][2] leftmost, [r][0] rightmost
//   win_col       : column of the presented window
//   last          : presented window ends the run
//   busy          : scan in progress
//   err           : one-cycle pulse on a start with an out-of-range column
module sobel_window_scanner
  import sobel_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ROW_LEN = 8,
  parameter int COL_W   = $clog2(ROW_LEN)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [2:0][ROW_LEN-1:0][PIX_W-1:0]     in_buffer,
  input  logic [COL_W-1:0]                       start_col,
  input  logic                                   scan_all,
  input  logic [1:0]                             edge_mode,
  input  logic                                   out_ready,
  output logic                                   win_valid,
  output logic [2:0][2:0][PIX_W-1:0]             sobel_matrix,
  output logic [COL_W-1:0]                       win_col,
  output logic                                   last,
  output logic                                   busy,
  output logic                                   err
);

  localparam logic [COL_W:0] ROW_LEN_W  = (COL_W+1)'(ROW_LEN);
  localparam logic [COL_W:0] LAST_COL_W = (COL_W+1)'(ROW_LEN - 1);

  scan_state_t state_q, state_d;

  logic [KERNEL-1:0][ROW_LEN-1:0][PIX_W-1:0] shadow_q;
  edge_mode_t                                mode_q;
  logic                                      scan_all_q;
  logic [COL_W-1:0]                          col_q;
  logic                                      last_q;
  logic                                      err_q;
  logic [KERNEL-1:0][KERNEL-1:0][PIX_W-1:0]  matrix_q;

  logic start_ok, start_bad, advance, finish;

  // Window source: live inputs when starting, captured copies while scanning.
  logic [KERNEL-1:0][ROW_LEN-1:0][PIX_W-1:0] sel_rows;
  logic [COL_W-1:0]                          sel_col;
  edge_mode_t                                sel_mode;
  logic                                      sel_scan_all;
  logic                                      next_last;
  logic [KERNEL-1:0][KERNEL-1:0][PIX_W-1:0]  matrix_d;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, start_col} < ROW_LEN_W) begin
            start_ok = 1'b1;
            state_d  = SCAN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      SCAN: begin
        // A start here is ignored, including one coinciding with the final accept.
        advance = out_ready & ~last_q;
        finish  = out_ready & last_q;
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- window datapath ----------------
  always_comb begin
    sel_rows     = shadow_q;
    sel_col      = col_q + 1'b1;
    sel_mode     = mode_q;
    sel_scan_all = scan_all_q;
    if (state_q == IDLE) begin
      sel_rows     = in_buffer;
      sel_col      = start_col;
      sel_mode     = edge_mode_t'(edge_mode);
      sel_scan_all = scan_all;
    end
  end

  assign next_last = ~sel_scan_all | ({1'b0, sel_col} == LAST_COL_W);

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    sobel_col_select #(
      .PIX_W   (PIX_W),
      .ROW_LEN (ROW_LEN),
      .COL_W   (COL_W)
    ) u_col_select (
      .row       (sel_rows[r]),
      .col       (sel_col),
      .edge_mode (sel_mode),
      .pix       (matrix_d[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow buffer is cleared on reset so no previous frame's pixels survive a reset.
      shadow_q   <= '0;
      mode_q     <= EDGE_WRAP;
      scan_all_q <= 1'b0;
      col_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      matrix_q   <= '0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        shadow_q   <= in_buffer;
        mode_q     <= edge_mode_t'(edge_mode);
        scan_all_q <= scan_all;
      end
      // The next window registers on the same edge that accepts the current one.
      if (start_ok || advance) begin
        col_q    <= sel_col;
        matrix_q <= matrix_d;
        last_q   <= next_last;
      end else if (finish) begin
        last_q <= 1'b0;  // matrix and column hold their final values
      end
    end
  end

  assign win_valid    = (state_q == SCAN);
  assign busy         = (state_q == SCAN);
  assign last         = last_q;
  assign win_col      = col_q;
  assign sobel_matrix = matrix_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sobel_window_scanner.sv
// Self-checking bench for sobel_window_scanner.
// Main instance (ROW_LEN=8) is checked by a scoreboard: each start pushes the
// expected windows of the run, a negedge monitor compares every presented window
// against the queue head and pops it when the window is accepted.
// A second instance (ROW_LEN=6) covers out-of-range start rejection.
module tb_sobel_window_scanner;

  localparam int L  = 8;
  localparam int PW = 8;

  typedef logic [2:0][L-1:0][PW-1:0] rows_t;
  typedef logic [L-1:0][PW-1:0]      row_t;

  typedef struct packed {
    logic [2:0][2:0][PW-1:0] m;
    logic [2:0]              col;
    logic                    last;
  } win_t;

  logic tb_clk = 1'b0;
  logic rst;

  // main instance
  logic                    start, scan_all, out_ready;
  rows_t                   in_buffer;
  logic [2:0]              start_col;
  logic [1:0]              edge_mode;
  logic                    win_valid, last, busy, err;
  logic [2:0][2:0][PW-1:0] sobel_matrix;
  logic [2:0]              win_col;

  // ROW_LEN=6 instance
  logic                    b_start, b_scan_all, b_out_ready;
  logic [2:0][5:0][PW-1:0] b_in_buffer;
  logic [2:0]              b_start_col;
  logic [1:0]              b_edge_mode;
  logic                    b_win_valid, b_last, b_busy, b_err;
  logic [2:0][2:0][PW-1:0] b_sobel_matrix;
  logic [2:0]              b_win_col;

  int checks = 0;
  int errors = 0;
  win_t exp_q[$];

  always #5 tb_clk = ~tb_clk;

  sobel_window_scanner #(.PIX_W(PW), .ROW_LEN(L)) dut (
    .clk(tb_clk), .rst(rst), .start(start), .in_buffer(in_buffer),
    .start_col(start_col), .scan_all(scan_all), .edge_mode(edge_mode),
    .out_ready(out_ready), .win_valid(win_valid), .sobel_matrix(sobel_matrix),
    .win_col(win_col), .last(last), .busy(busy), .err(err)
  );

  sobel_window_scanner #(.PIX_W(PW), .ROW_LEN(6)) dut6 (
    .clk(tb_clk), .rst(rst), .start(b_start), .in_buffer(b_in_buffer),
    .start_col(b_start_col), .scan_all(b_scan_all), .edge_mode(b_edge_mode),
    .out_ready(b_out_ready), .win_valid(b_win_valid), .sobel_matrix(b_sobel_matrix),
    .win_col(b_win_col), .last(b_last), .busy(b_busy), .err(b_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel p counted from the left edge of row r.
  function automatic logic [PW-1:0] px(input rows_t rows, input int r, input int p);
    return rows[r][L-1-p];
  endfunction

  function automatic win_t ref_window(input rows_t rows, input int c, input int mode, input bit sa);
    win_t w;
    w.m = '0;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) begin
        int s = c + j;
        logic [PW-1:0] v;
        if (s < L)          v = px(rows, r, s);
        else if (mode == 0) v = px(rows, r, s - L);
        else if (mode == 2) v = px(rows, r, L - 1);
        else                v = '0;
        w.m[r][2-j] = v;
      end
    w.col  = 3'(c);
    w.last = !sa || (c == L - 1);
    return w;
  endfunction

  function automatic rows_t same_rows(input row_t r);
    return {r, r, r};
  endfunction

  function automatic rows_t rand_rows();
    rows_t x;
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < L; p++) x[r][p] = PW'($urandom);
    return x;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge tb_clk) begin
    if (!rst && win_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got col %0d expected no window", win_col);
      end else begin
        check("win_matrix", sobel_matrix, exp_q[0].m);
        check("win_col",    win_col,      exp_q[0].col);
        check("win_last",   last,         exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic do_start(input rows_t rows, input int sc, input bit sa, input int mode);
    in_buffer = rows;
    start_col = 3'(sc);
    scan_all  = sa;
    edge_mode = 2'(mode);
    start     = 1'b1;
    for (int c = sc; c < (sa ? L : sc + 1); c++) exp_q.push_back(ref_window(rows, c, mode, sa));
    @(posedge tb_clk); #1;
    start = 1'b0;
    // Scramble inputs: the run must use the captured copies.
    in_buffer = rand_rows();
    start_col = 3'($urandom);
    scan_all  = 1'($urandom);
    edge_mode = 2'($urandom);
  endtask

  task automatic wait_done(input bit rand_ready);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      if (rand_ready) out_ready = 1'($urandom);
      @(posedge tb_clk); #1;
      n++;
    end
    check("run_done_busy", busy, 0);
    check("run_done_sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  win_valid,    0);
    check({tag, "_busy"},   busy,         0);
    check({tag, "_last"},   last,         0);
    check({tag, "_err"},    err,          0);
    check({tag, "_col"},    win_col,      0);
    check({tag, "_matrix"}, sobel_matrix, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    win_t  w;
    rows_t rows_a, rows_b, rows_c;
    int    n;

    rst = 1'b1;
    start = 0; scan_all = 0; out_ready = 1; in_buffer = '0; start_col = '0; edge_mode = '0;
    b_start = 0; b_scan_all = 0; b_out_ready = 1; b_in_buffer = '0; b_start_col = '0; b_edge_mode = '0;
    #1;
    check_all_zero("reset");
    @(posedge tb_clk); #1;
    rst = 1'b0;
    @(posedge tb_clk); #1;

    rows_a = same_rows({8'd5, 8'd55, 8'd50, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0});
    rows_b = same_rows({8'd0, 8'd55, 8'd50, 8'd100, 8'd0, 8'd20, 8'd0, 8'd9});
    rows_c = same_rows({8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});

    // Single window, wrap; a start coinciding with the final accept is ignored.
    w = ref_window(rows_a, 6, 0, 0);
    check("wrap_model_row", w.m[1], 24'h000005);
    do_start(rows_a, 6, 0, 0);
    check("wrap_valid", win_valid, 1);
    check("wrap_last", last, 1);
    check("wrap_col", win_col, 6);
    check("wrap_row0", sobel_matrix[0], 24'h000005);
    start = 1'b1;
    start_col = 3'd0;
    @(posedge tb_clk); #1;
    start = 1'b0;
    check("wrap_after_valid", win_valid, 0);
    check("wrap_after_busy", busy, 0);
    check("wrap_matrix_hold", sobel_matrix, w.m);
    @(posedge tb_clk); #1;
    check("start_at_final_ignored", busy, 0);

    // Single window, zero-pad and replicate.
    do_start(rows_a, 7, 0, 1);
    check("zero_row2", sobel_matrix[2], 24'h000000);
    wait_done(0);
    do_start(rows_b, 7, 0, 2);
    check("repl_row1", sobel_matrix[1], 24'h090909);
    wait_done(0);

    // Auto-scan with backpressure; a start during SCAN is ignored without err.
    out_ready = 1'b0;
    do_start(rows_c, 4, 1, 1);
    check("bp_first_col", win_col, 4);
    @(posedge tb_clk); #1;
    start = 1'b1;
    start_col = 3'd0;
    @(posedge tb_clk); #1;
    start = 1'b0;
    check("start_in_scan_err", err, 0);
    check("start_in_scan_col", win_col, 4);
    out_ready = 1'b1;
    wait_done(0);

    // Back-to-back scan from column 0: no bubbles.
    do_start(rows_c, 0, 1, 1);
    check("b2b_row_col0", sobel_matrix[0], 24'h646464);
    for (int k = 0; k < L; k++) begin
      check("b2b_valid", win_valid, 1);
      check("b2b_col", win_col, k);
      if (k == 1) check("b2b_row_col1", sobel_matrix[2], 24'h646400);
      @(posedge tb_clk); #1;
    end
    check("b2b_done", win_valid, 0);
    exp_q.delete();

    // Reset mid-run at column 5, then a fresh run.
    do_start(rand_rows(), 0, 1, 0);
    n = 0;
    while (win_col != 3'd5 && n < 20) begin
      @(posedge tb_clk); #1;
      n++;
    end
    check("reach_col5", win_col, 5);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_valid", win_valid, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_err", err, 0);
    exp_q.delete();
    @(posedge tb_clk); #1;
    rst = 1'b0;
    @(posedge tb_clk); #1;
    do_start(rand_rows(), 3, 0, 2);
    wait_done(0);

    // Asynchronous reset between edges while a window is stalled.
    out_ready = 1'b0;
    do_start(rows_b, 5, 1, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge tb_clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge tb_clk); #1;

    // Reject: ROW_LEN=6 with start_col 7 and 6.
    b_in_buffer = {3{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}};
    b_start = 1'b1;
    b_start_col = 3'd7;
    @(posedge tb_clk); #1;
    b_start = 1'b0;
    check("rej7_err", b_err, 1);
    check("rej7_valid", b_win_valid, 0);
    check("rej7_busy", b_busy, 0);
    @(posedge tb_clk); #1;
    check("rej7_err_pulse", b_err, 0);
    b_start = 1'b1;
    b_start_col = 3'd6;
    @(posedge tb_clk); #1;
    b_start = 1'b0;
    check("rej6_err", b_err, 1);
    check("rej6_valid", b_win_valid, 0);
    @(posedge tb_clk); #1;
    b_start = 1'b1;
    b_start_col = 3'd5;
    b_edge_mode = 2'd0;
    @(posedge tb_clk); #1;
    b_start = 1'b0;
    check("len6_valid", b_win_valid, 1);
    check("len6_err", b_err, 0);
    check("len6_col", b_win_col, 5);
    check("len6_wrap", b_sobel_matrix, {3{24'h060102}});
    @(posedge tb_clk); #1;
    check("len6_done", b_win_valid, 0);

    // Randomized runs with random backpressure.
    for (int t = 0; t < 30; t++) begin
      out_ready = 1'($urandom);
      do_start(rand_rows(), $urandom_range(0, L - 1), 1'($urandom), $urandom_range(0, 3));
      wait_done(1);
    end
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
